// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared constants and state encoding for the M-extension issue controller.
package muldiv_issue_ctrl_pkg;

  // RISC-V M-extension funct3 encodings
  localparam logic [2:0] MULf3    = 3'b000;
  localparam logic [2:0] MULHf3   = 3'b001;
  localparam logic [2:0] MULHSUf3 = 3'b010;
  localparam logic [2:0] MULHUf3  = 3'b011;
  localparam logic [2:0] DIVf3    = 3'b100;
  localparam logic [2:0] DIVUf3   = 3'b101;
  localparam logic [2:0] REMf3    = 3'b110;
  localparam logic [2:0] REMUf3   = 3'b111;

  // Dividend that overflows a signed divide by -1
  localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL       = 3'd1,
    DIV_START = 3'd2,
    DIV_WAIT  = 3'd3,
    FIX       = 3'd4,
    DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for DIV/REM: operand magnitudes, corner-case detection and
// final result sign correction / override.
module muldiv_sign_fix
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      i_op,       // {is_rem, is_unsigned} = funct3[1:0]
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_r,
  output logic [XLEN-1:0] o_mag_a,
  output logic [XLEN-1:0] o_mag_b,
  output logic            o_div_zero,
  output logic            o_ovf,
  output logic [XLEN-1:0] o_result
);

  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_ovf_a;

  assign w_signed   = ~i_op[0];
  assign w_neg_a    = w_signed & i_a[XLEN-1];
  assign w_neg_b    = w_signed & i_b[XLEN-1];
  assign w_ovf_a    = {1'b1, {(XLEN-1){1'b0}}};
  assign o_mag_a    = w_neg_a ? -i_a : i_a;
  assign o_mag_b    = w_neg_b ? -i_b : i_b;
  assign o_div_zero = (i_b == '0);
  assign o_ovf      = w_signed && (i_a == w_ovf_a) && (i_b == '1);

  // Corner cases win over the divider outputs, which are not valid for them
  always_comb begin
    o_result = '0;
    if (!i_op[1]) begin
      if (o_div_zero)              o_result = '1;
      else if (o_ovf)              o_result = w_ovf_a;
      else if (w_neg_a ^ w_neg_b)  o_result = -i_q;
      else                         o_result = i_q;
    end else begin
      if (o_div_zero)              o_result = i_a;
      else if (o_ovf)              o_result = '0;
      else if (w_neg_a)            o_result = -i_r;
      else                         o_result = i_r;
    end
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Core-side initiator for the MUL/DIV coprocessor: issues one op, drives the
// multiplier and iterative divider, stalls the pipeline and returns a
// registered writeback beat.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue_valid,
  input  logic [2:0]        i_issue_funct3,
  input  logic [XLEN-1:0]   i_issue_a,
  input  logic [XLEN-1:0]   i_issue_b,
  input  logic [4:0]        i_issue_rd,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_mul_a,
  output logic [XLEN-1:0]   o_mul_b,
  output logic              o_mul_sig_a,
  output logic              o_mul_sig_b,
  input  logic [2*XLEN-1:0] i_mul_p,
  output logic              o_div_start,
  output logic [XLEN-1:0]   o_div_a,
  output logic [XLEN-1:0]   o_div_b,
  input  logic              i_div_ok,
  input  logic [XLEN-1:0]   i_div_q,
  input  logic [XLEN-1:0]   i_div_r,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data
);

  state_e          r_state, w_state_d;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_mul_a, r_mul_b, r_div_a, r_div_b, r_q, r_r, r_wb_data;
  logic            r_mul_sig_a, r_mul_sig_b, r_div_start, r_prev_ok;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;

  logic            w_idle, w_accept, w_div_done;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_a, w_b, w_mag_a, w_mag_b, w_fix_result, w_mul_result;
  logic            w_div_zero, w_ovf;

  assign w_idle     = (r_state == IDLE);
  assign w_accept   = w_idle && i_issue_valid;
  assign w_div_done = i_div_ok && !r_prev_ok;

  // Sign-fix sees the live issue operands in IDLE and the latched op afterwards
  assign w_f3 = w_idle ? i_issue_funct3 : r_f3;
  assign w_a  = w_idle ? i_issue_a      : r_mul_a;
  assign w_b  = w_idle ? i_issue_b      : r_mul_b;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_op       (w_f3[1:0]),
    .i_a        (w_a),
    .i_b        (w_b),
    .i_q        (r_q),
    .i_r        (r_r),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .o_div_zero (w_div_zero),
    .o_ovf      (w_ovf),
    .o_result   (w_fix_result)
  );

  assign w_mul_result = (r_f3 == MULf3) ? i_mul_p[XLEN-1:0] : i_mul_p[2*XLEN-1:XLEN];

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_issue_valid) begin
          if (!i_issue_funct3[2])         w_state_d = MUL;
          else if (w_div_zero || w_ovf)   w_state_d = FIX;
          else                            w_state_d = DIV_START;
        end
      end
      MUL:       w_state_d = DONE;
      DIV_START: w_state_d = DIV_WAIT;
      DIV_WAIT:  if (w_div_done) w_state_d = FIX;
      FIX:       w_state_d = DONE;
      DONE:      w_state_d = IDLE;
      default:   w_state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // Operand latching, divider handshake and writeback registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_f3        <= '0;
      r_rd        <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_sig_a <= 1'b0;
      r_mul_sig_b <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_start <= 1'b0;
      r_prev_ok   <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
    end else begin
      r_prev_ok   <= i_div_ok;
      r_div_start <= w_idle && (w_state_d == DIV_START);
      r_wb_valid  <= (w_state_d == DONE);
      if (w_accept) begin
        r_f3        <= i_issue_funct3;
        r_rd        <= i_issue_rd;
        r_mul_a     <= i_issue_a;
        r_mul_b     <= i_issue_b;
        r_mul_sig_a <= (i_issue_funct3 == MULHf3) || (i_issue_funct3 == MULHSUf3);
        r_mul_sig_b <= (i_issue_funct3 == MULHf3);
        r_div_a     <= w_mag_a;
        r_div_b     <= w_mag_b;
      end
      if ((r_state == DIV_WAIT) && w_div_done) begin
        r_q <= i_div_q;
        r_r <= i_div_r;
      end
      if (r_state == MUL) begin
        r_wb_data <= w_mul_result;
        r_wb_rd   <= r_rd;
      end else if (r_state == FIX) begin
        r_wb_data <= w_fix_result;
        r_wb_rd   <= r_rd;
      end
    end
  end

  // Stall drops in DONE so the op retires
  always_comb begin
    o_stall = w_accept || (r_state == MUL) || (r_state == DIV_START) ||
              (r_state == DIV_WAIT) || (r_state == FIX);
  end

  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_mul_sig_a = r_mul_sig_a;
  assign o_mul_sig_b = r_mul_sig_b;
  assign o_div_start = r_div_start;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench: directed and randomized MUL/DIV/REM ops against a
// plain-arithmetic reference model, with a multiplier and divider model.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic        stall;
  logic [31:0] mul_a, mul_b;
  logic        mul_sig_a, mul_sig_b;
  logic [63:0] mul_p;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic        div_ok;
  logic [31:0] div_q, div_r;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_pass = 0;
  int n_total = 0;
  int n_wb = 0;
  int n_ds = 0;
  int div_lat = 32;
  logic [31:0] cap_div_a = '0, cap_div_b = '0;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.XLEN(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_issue_valid  (issue_valid),
    .i_issue_funct3 (issue_funct3),
    .i_issue_a      (issue_a),
    .i_issue_b      (issue_b),
    .i_issue_rd     (issue_rd),
    .o_stall        (stall),
    .o_mul_a        (mul_a),
    .o_mul_b        (mul_b),
    .o_mul_sig_a    (mul_sig_a),
    .o_mul_sig_b    (mul_sig_b),
    .i_mul_p        (mul_p),
    .o_div_start    (div_start),
    .o_div_a        (div_a),
    .o_div_b        (div_b),
    .i_div_ok       (div_ok),
    .i_div_q        (div_q),
    .i_div_r        (div_r),
    .o_wb_valid     (wb_valid),
    .o_wb_rd        (wb_rd),
    .o_wb_data      (wb_data)
  );

  // Combinational multiplier: extend per signedness flag, keep 64 bits
  logic [63:0] ext_a, ext_b;
  assign ext_a = mul_sig_a ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
  assign ext_b = mul_sig_b ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
  assign mul_p = ext_a * ext_b;

  // Unsigned iterative divider: busy for div_lat cycles after start
  logic dv_busy;
  int   dv_cnt;
  logic [31:0] dv_q, dv_r;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_busy <= 1'b0; dv_cnt <= 0; dv_q <= '0; dv_r <= '0;
    end else if (div_start && !dv_busy) begin
      dv_busy <= 1'b1;
      dv_cnt  <= div_lat - 1;
      dv_q    <= (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
      dv_r    <= (div_b == 0) ? div_a : div_a % div_b;
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else             dv_cnt  <= dv_cnt - 1;
    end
  end
  assign div_ok = ~dv_busy;
  assign div_q  = dv_q;
  assign div_r  = dv_r;

  // Event monitors
  always @(negedge clk) begin
    if (wb_valid)  n_wb <= n_wb + 1;
    if (div_start) begin
      n_ds      <= n_ds + 1;
      cap_div_a <= div_a;
      cap_div_b <= div_b;
    end
  end

  // Reference model from RISC-V M-extension semantics
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'b000:  begin p = ua * ub;            return p[31:0];  end
      3'b001:  begin p = sa * sb;            return p[63:32]; end
      3'b010:  begin p = sa * longint'(ub);  return p[63:32]; end
      3'b011:  begin p = ua * ub;            return p[63:32]; end
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'b110:  return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] ref_mag(input logic [2:0] f3, input logic [31:0] x);
    if (!f3[0] && x[31]) return 32'(-longint'($signed(x)));
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for a wb_valid strobe, sampled mid-cycle; returns cycle count or -1
  task automatic wait_wb(input int budget, output int cyc, output logic [31:0] data,
                         output logic [4:0] rd, output bit stall_ok);
    cyc = -1; data = '0; rd = '0; stall_ok = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (wb_valid === 1'b1) begin
        cyc = c; data = wb_data; rd = wb_rd;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data);
    int          wb0, ds0, cyc, exp_lat, exp_ds;
    bit          byp, stall_ok, issue_stall;
    logic [31:0] got;
    logic [4:0]  got_rd;
    byp     = f3[2] && ((b == 0) || (!f3[0] && a == DIV_OVF_A && b == 32'hFFFF_FFFF));
    exp_ds  = (f3[2] && !byp) ? 1 : 0;
    exp_lat = (exp_ds == 1) ? 4 + div_lat : 2;
    @(negedge clk);
    wb0 = n_wb; ds0 = n_ds;
    issue_valid = 1'b1; issue_funct3 = f3; issue_a = a; issue_b = b; issue_rd = rd;
    #1 issue_stall = (stall === 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    wait_wb(exp_lat + 20, cyc, got, got_rd, stall_ok);
    chk({tag, "_lat"},   64'(cyc), 64'(exp_lat));
    chk({tag, "_data"},  64'(got), 64'(exp_data));
    chk({tag, "_rd"},    64'(got_rd), 64'(rd));
    chk({tag, "_stall"}, 64'(stall_ok && issue_stall), 64'(1));
    @(negedge clk); #2;
    chk({tag, "_nwb"},   64'(n_wb - wb0), 64'(1));
    chk({tag, "_nstart"}, 64'(n_ds - ds0), 64'(exp_ds));
    if (exp_ds == 1) begin
      chk({tag, "_diva"}, 64'(cap_div_a), 64'(ref_mag(f3, a)));
      chk({tag, "_divb"}, 64'(cap_div_b), 64'(ref_mag(f3, b)));
    end
  endtask

  initial begin
    int          wb0, cyc;
    logic [31:0] d1, d2, ra, rb;
    logic [4:0]  r1;
    logic [2:0]  rf;
    bit          sok;

    rst = 1'b0; issue_valid = 1'b0; issue_funct3 = '0; issue_a = '0; issue_b = '0;
    issue_rd = '0;
    #12;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_wbv",   64'(wb_valid), 64'(0));
    chk("rst_wbd",   64'(wb_data), 64'(0));
    chk("rst_start", 64'(div_start), 64'(0));
    chk("rst_mula",  64'(mul_a), 64'(0));
    chk("rst_diva",  64'(div_a), 64'(0));
    @(negedge clk) rst = 1'b1;

    // Multiplies
    run_op("mulh",  MULHf3,  32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF);
    run_op("mulhu", MULHUf3, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'h0000_0001);
    run_op("mul",   MULf3,   32'd7, 32'd6, 5'd5, 32'd42);
    run_op("mulhsu", MULHSUf3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);

    // Signed divide with nominal divider
    div_lat = 32;
    run_op("div",  DIVf3, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
    run_op("rem",  REMf3, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);

    // Divide by zero and overflow bypass
    run_op("divu0", DIVUf3, 32'd100, 32'd0, 5'd9,  32'hFFFF_FFFF);
    run_op("remu0", REMUf3, 32'd100, 32'd0, 5'd10, 32'd100);
    run_op("div0",  DIVf3,  32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_op("dovf",  DIVf3,  DIV_OVF_A, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    run_op("rovf",  REMf3,  DIV_OVF_A, 32'hFFFF_FFFF, 5'd13, 32'h0);

    // Reset during DIV_WAIT aborts with no writeback
    @(negedge clk);
    issue_valid = 1'b1; issue_funct3 = DIVf3; issue_a = 32'hFFFF_FF9C; issue_b = 32'd7;
    issue_rd = 5'd14;
    @(negedge clk) issue_valid = 1'b0;
    repeat (5) @(negedge clk);
    wb0 = n_wb;
    chk("pre_rst_stall", 64'(stall), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(stall), 64'(0));
    chk("mid_rst_wbv",   64'(wb_valid), 64'(0));
    chk("mid_rst_start", 64'(div_start), 64'(0));
    @(negedge clk) rst = 1'b1;
    repeat (40) @(negedge clk);
    #2 chk("mid_rst_nowb", 64'(n_wb - wb0), 64'(0));
    run_op("divu93", DIVUf3, 32'd9, 32'd3, 5'd15, 32'd3);

    // issue_valid held high: DIVU then REMU back to back
    @(negedge clk);
    wb0 = n_wb;
    issue_valid = 1'b1; issue_funct3 = DIVUf3; issue_a = 32'd10; issue_b = 32'd3;
    issue_rd = 5'd16;
    @(negedge clk);
    wait_wb(80, cyc, d1, r1, sok);
    issue_funct3 = REMUf3;
    @(negedge clk);
    wait_wb(80, cyc, d2, r1, sok);
    issue_valid = 1'b0;
    chk("held_d1", 64'(d1), 64'(3));
    chk("held_d2", 64'(d2), 64'(1));
    repeat (40) @(negedge clk);
    #2 chk("held_nwb", 64'(n_wb - wb0), 64'(2));

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = DIV_OVF_A;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      div_lat = $urandom_range(1, 40);
      run_op($sformatf("rand%0d", i), rf, ra, rb, 5'($urandom), ref_result(rf, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
